// File: rtl/digest_serializer.sv
// Purpose: unloads one wide permutation-state block as a stream of 32-bit words, MSB word first.
// Latency: first word valid 1 cycle after the in_ack edge; one block every WORDS+1 cycles minimum.
// Backpressure: out_accept=0 holds the current word, flags and counter; no new block is acked until the last word leaves.
module digest_serializer #(
    parameter int IN_WIDTH     = 576,
    parameter int DIGEST_BYTES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] in,
    input  logic                in_ready,
    output logic                in_ack,
    output logic [31:0]         out,
    output logic                out_valid,
    input  logic                out_accept,
    output logic                is_last,
    output logic [1:0]          byte_num,
    output logic                busy
);

    localparam int WORDS = (DIGEST_BYTES + 3) / 4;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int REM   = DIGEST_BYTES % 4;

    localparam logic [CW-1:0] LAST_CNT   = CW'(WORDS - 1);
    localparam logic [1:0]    LAST_BYTES = 2'(REM);
    // Keeps only the valid top bytes of a partial final word.
    localparam logic [31:0]   LAST_MASK  = (REM == 0) ? 32'hFFFF_FFFF
                                                      : ~(32'hFFFF_FFFF >> (8 * REM));

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IN_WIDTH-1:0] buffer;
    logic [CW-1:0]       count;

    // Next-state and output decode; in_ack is also gated by reset so every output is 0 while reset is held.
    always_comb begin
        state_nxt = state;
        in_ack    = 1'b0;
        out_valid = 1'b0;
        is_last   = 1'b0;
        byte_num  = 2'd0;
        out       = 32'd0;
        case (state)
            IDLE: begin
                in_ack = in_ready & reset;
                if (in_ack) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                is_last   = (count == LAST_CNT);
                out       = buffer[IN_WIDTH-1 -: 32] & (is_last ? LAST_MASK : 32'hFFFF_FFFF);
                byte_num  = is_last ? LAST_BYTES : 2'd0;
                if (out_accept && is_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = out_valid;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Block buffer and word counter: load on capture, shift out on each accepted word, clear after the last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer <= '0;
            count  <= '0;
        end else if (state == IDLE) begin
            if (in_ack) begin
                buffer <= in;
                count  <= '0;
            end
        end else if (out_accept) begin
            if (is_last) begin
                buffer <= '0;
                count  <= '0;
            end else begin
                buffer <= buffer << 32;
                count  <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_digest_serializer.sv
// Directed bench for digest_serializer: default 64-byte digest plus 28- and 30-byte instances.
module tb_digest_serializer;

    logic         clk;
    logic         reset;
    logic [575:0] blk;
    logic         out_accept;
    logic         rdy_def, rdy_28, rdy_30;

    logic        ack_def, vld_def, last_def, busy_def;
    logic [31:0] out_def;
    logic [1:0]  bn_def;
    logic        ack_28, vld_28, last_28, busy_28;
    logic [31:0] out_28;
    logic [1:0]  bn_28;
    logic        ack_30, vld_30, last_30, busy_30;
    logic [31:0] out_30;
    logic [1:0]  bn_30;

    int total;
    int bad;

    digest_serializer #(.IN_WIDTH(576), .DIGEST_BYTES(64)) u_def (
        .clk(clk), .reset(reset), .in(blk), .in_ready(rdy_def), .in_ack(ack_def),
        .out(out_def), .out_valid(vld_def), .out_accept(out_accept),
        .is_last(last_def), .byte_num(bn_def), .busy(busy_def));

    digest_serializer #(.IN_WIDTH(576), .DIGEST_BYTES(28)) u_28 (
        .clk(clk), .reset(reset), .in(blk), .in_ready(rdy_28), .in_ack(ack_28),
        .out(out_28), .out_valid(vld_28), .out_accept(out_accept),
        .is_last(last_28), .byte_num(bn_28), .busy(busy_28));

    digest_serializer #(.IN_WIDTH(576), .DIGEST_BYTES(30)) u_30 (
        .clk(clk), .reset(reset), .in(blk), .in_ready(rdy_30), .in_ack(ack_30),
        .out(out_30), .out_valid(vld_30), .out_accept(out_accept),
        .is_last(last_30), .byte_num(bn_30), .busy(busy_30));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word k (counted from the MSB) of the block is base + k.
    function automatic logic [575:0] make_block(input logic [31:0] base);
        logic [575:0] b;
        b = '0;
        for (int k = 0; k < 18; k++) begin
            b[575 - 32*k -: 32] = base + 32'(k);
        end
        return b;
    endfunction

    task automatic test_reset;
        reset = 1'b0; rdy_def = 1'b1; out_accept = 1'b1; blk = make_block(32'h0);
        repeat (3) begin
            @(negedge clk); #1;
            total++; if (vld_def !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", vld_def); end
            total++; if (ack_def !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", ack_def); end
            total++; if (out_def !== 32'h0) begin bad++; $display("FAIL rst_out: got %h want 0", out_def); end
            total++; if (busy_def !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_def); end
        end
        @(negedge clk); reset = 1'b1; #1;
        total++; if (ack_def !== 1'b1) begin bad++; $display("FAIL rst_first_ack: got %b want 1", ack_def); end
        @(negedge clk); rdy_def = 1'b0; #1;
        total++; if (vld_def !== 1'b1 || out_def !== 32'h0) begin bad++; $display("FAIL rst_first_word: got vld=%b out=%h want vld=1 out=0", vld_def, out_def); end
        repeat (16) @(negedge clk);
        #1;
        total++; if (vld_def !== 1'b0) begin bad++; $display("FAIL rst_drain: got %b want 0", vld_def); end
    endtask

    task automatic test_stream;
        @(negedge clk); blk = make_block(32'h0); rdy_def = 1'b1; out_accept = 1'b1; #1;
        total++; if (ack_def !== 1'b1) begin bad++; $display("FAIL stream_ack: got %b want 1", ack_def); end
        @(negedge clk); rdy_def = 1'b0; blk = make_block(32'hDEAD_0000);
        for (int k = 0; k < 16; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            total++; if (vld_def !== 1'b1) begin bad++; $display("FAIL stream_valid w%0d: got %b want 1", k, vld_def); end
            total++; if (out_def !== 32'(k)) begin bad++; $display("FAIL stream_word w%0d: got %h want %h", k, out_def, 32'(k)); end
            total++; if (last_def !== (k == 15)) begin bad++; $display("FAIL stream_last w%0d: got %b want %b", k, last_def, (k == 15)); end
            total++; if (bn_def !== 2'd0) begin bad++; $display("FAIL stream_bytes w%0d: got %0d want 0", k, bn_def); end
            total++; if (ack_def !== 1'b0) begin bad++; $display("FAIL stream_noack w%0d: got %b want 0", k, ack_def); end
        end
        @(negedge clk); #1;
        total++; if (vld_def !== 1'b0 || out_def !== 32'h0) begin bad++; $display("FAIL stream_end: got vld=%b out=%h want vld=0 out=0", vld_def, out_def); end
    endtask

    task automatic test_backpressure;
        int idx, cyc;
        @(negedge clk); blk = make_block(32'h0); rdy_def = 1'b1; #1;
        total++; if (ack_def !== 1'b1) begin bad++; $display("FAIL bp_ack: got %b want 1", ack_def); end
        @(negedge clk); rdy_def = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 16 && cyc < 100) begin
            out_accept = ((cyc % 3) == 0);
            #1;
            total++; if (vld_def !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d: got %b want 1", cyc, vld_def); end
            total++; if (out_def !== 32'(idx)) begin bad++; $display("FAIL bp_word c%0d: got %h want %h", cyc, out_def, 32'(idx)); end
            total++; if (last_def !== (idx == 15)) begin bad++; $display("FAIL bp_last c%0d: got %b want %b", cyc, last_def, (idx == 15)); end
            if (out_accept) idx++;
            cyc++;
            @(negedge clk);
        end
        out_accept = 1'b1; #1;
        total++; if (idx != 16) begin bad++; $display("FAIL bp_count: got %0d want 16", idx); end
        total++; if (cyc != 46) begin bad++; $display("FAIL bp_cycles: got %0d want 46", cyc); end
        total++; if (vld_def !== 1'b0) begin bad++; $display("FAIL bp_end: got %b want 0", vld_def); end
    endtask

    task automatic test_digest28;
        @(negedge clk); blk = make_block(32'h5500_0000); rdy_28 = 1'b1; out_accept = 1'b1; #1;
        total++; if (ack_28 !== 1'b1) begin bad++; $display("FAIL d28_ack: got %b want 1", ack_28); end
        @(negedge clk); rdy_28 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            total++; if (vld_28 !== 1'b1 || out_28 !== 32'h5500_0000 + 32'(k)) begin bad++; $display("FAIL d28_word w%0d: got vld=%b out=%h want vld=1 out=%h", k, vld_28, out_28, 32'h5500_0000 + 32'(k)); end
            total++; if (last_28 !== (k == 6) || bn_28 !== 2'd0) begin bad++; $display("FAIL d28_flags w%0d: got last=%b bytes=%0d want last=%b bytes=0", k, last_28, bn_28, (k == 6)); end
        end
        @(negedge clk); #1;
        total++; if (vld_28 !== 1'b0) begin bad++; $display("FAIL d28_end: got %b want 0", vld_28); end
    endtask

    task automatic test_digest30;
        @(negedge clk); blk = make_block(32'hA5A5_0000); rdy_30 = 1'b1; out_accept = 1'b1; #1;
        total++; if (ack_30 !== 1'b1) begin bad++; $display("FAIL d30_ack: got %b want 1", ack_30); end
        @(negedge clk); rdy_30 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            total++; if (vld_30 !== 1'b1 || out_30 !== 32'hA5A5_0000 + 32'(k)) begin bad++; $display("FAIL d30_word w%0d: got vld=%b out=%h want vld=1 out=%h", k, vld_30, out_30, 32'hA5A5_0000 + 32'(k)); end
            total++; if (last_30 !== 1'b0 || bn_30 !== 2'd0) begin bad++; $display("FAIL d30_flags w%0d: got last=%b bytes=%0d want last=0 bytes=0", k, last_30, bn_30); end
        end
        @(negedge clk); #1;
        total++; if (out_30 !== 32'hA5A5_0000) begin bad++; $display("FAIL d30_lastword: got %h want a5a50000", out_30); end
        total++; if (last_30 !== 1'b1) begin bad++; $display("FAIL d30_last: got %b want 1", last_30); end
        total++; if (bn_30 !== 2'd2) begin bad++; $display("FAIL d30_bytes: got %0d want 2", bn_30); end
        @(negedge clk); #1;
        total++; if (vld_30 !== 1'b0) begin bad++; $display("FAIL d30_end: got %b want 0", vld_30); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); blk = make_block(32'h0A00_0000); rdy_def = 1'b1; out_accept = 1'b1; #1;
        total++; if (ack_def !== 1'b1) begin bad++; $display("FAIL b2b_ack_a: got %b want 1", ack_def); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); blk = make_block(32'h0B00_0000); #1;
            total++; if (out_def !== 32'h0A00_0000 + 32'(k)) begin bad++; $display("FAIL b2b_word_a w%0d: got %h want %h", k, out_def, 32'h0A00_0000 + 32'(k)); end
            total++; if (ack_def !== 1'b0) begin bad++; $display("FAIL b2b_noack_a w%0d: got %b want 0", k, ack_def); end
            total++; if (last_def !== (k == 15)) begin bad++; $display("FAIL b2b_last_a w%0d: got %b want %b", k, last_def, (k == 15)); end
        end
        @(negedge clk); #1;
        total++; if (vld_def !== 1'b0 || ack_def !== 1'b1) begin bad++; $display("FAIL b2b_gap: got vld=%b ack=%b want vld=0 ack=1", vld_def, ack_def); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); rdy_def = 1'b0; #1;
            total++; if (vld_def !== 1'b1 || out_def !== 32'h0B00_0000 + 32'(k)) begin bad++; $display("FAIL b2b_word_b w%0d: got vld=%b out=%h want vld=1 out=%h", k, vld_def, out_def, 32'h0B00_0000 + 32'(k)); end
        end
        @(negedge clk); #1;
        total++; if (vld_def !== 1'b0 || ack_def !== 1'b0) begin bad++; $display("FAIL b2b_end: got vld=%b ack=%b want 0 0", vld_def, ack_def); end
    endtask

    task automatic test_async_reset;
        @(negedge clk); blk = make_block(32'h0C00_0000); rdy_def = 1'b1; out_accept = 1'b1; #1;
        total++; if (ack_def !== 1'b1) begin bad++; $display("FAIL ar_ack: got %b want 1", ack_def); end
        @(negedge clk); rdy_def = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        total++; if (vld_def !== 1'b1 || out_def !== 32'h0C00_0006) begin bad++; $display("FAIL ar_word6: got vld=%b out=%h want vld=1 out=0c000006", vld_def, out_def); end
        #2 reset = 1'b0; #1;
        total++; if (vld_def !== 1'b0 || busy_def !== 1'b0 || out_def !== 32'h0) begin bad++; $display("FAIL ar_drop: got vld=%b busy=%b out=%h want 0 0 0", vld_def, busy_def, out_def); end
        @(negedge clk); reset = 1'b1; #1;
        total++; if (vld_def !== 1'b0 || ack_def !== 1'b0) begin bad++; $display("FAIL ar_release: got vld=%b ack=%b want 0 0", vld_def, ack_def); end
        @(negedge clk); #1;
        total++; if (vld_def !== 1'b0) begin bad++; $display("FAIL ar_quiet: got %b want 0", vld_def); end
        @(negedge clk); blk = make_block(32'h0D00_0000); rdy_def = 1'b1; #1;
        total++; if (ack_def !== 1'b1) begin bad++; $display("FAIL ar_fresh_ack: got %b want 1", ack_def); end
        @(negedge clk); rdy_def = 1'b0; #1;
        total++; if (vld_def !== 1'b1 || out_def !== 32'h0D00_0000 || last_def !== 1'b0) begin bad++; $display("FAIL ar_fresh_word: got vld=%b out=%h last=%b want 1 0d000000 0", vld_def, out_def, last_def); end
        repeat (16) @(negedge clk);
        #1;
        total++; if (vld_def !== 1'b0) begin bad++; $display("FAIL ar_drain: got %b want 0", vld_def); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; blk = '0; out_accept = 1'b0;
        rdy_def = 1'b0; rdy_28 = 1'b0; rdy_30 = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_digest28();
        test_digest30();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digest_serializer.md
Name:
digest_serializer

Overview:
- Output-side counterpart of the input padder: converts one wide permutation-state block into a stream of 32-bit words for the user module.
- Sits between the f_permutation module (wide `in`, `in_ready`/`in_ack` handshake) and the user (32-bit `out`, valid/accept handshake).
- Emits the first DIGEST_BYTES bytes of the block, most-significant word first, with a last-word flag and a byte count.

Parameters:
- IN_WIDTH, 576, width of the state block from f_permutation; multiple of 32.
- DIGEST_BYTES, 64, number of bytes emitted per block; range 1..IN_WIDTH/8.
- Derived constant WORDS = ceil(DIGEST_BYTES/4).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  IN_WIDTH  state block from f_permutation; valid while in_ready=1.
- in_ready  input  1  f_permutation has a block available.
- in_ack  output  1  block captured this cycle.
- out  output  32  current output word.
- out_valid  output  1  `out`, is_last and byte_num are valid.
- out_accept  input  1  user takes the word this cycle.
- is_last  output  1  current word is the final word of the digest.
- byte_num  output  2  valid bytes in the last word; 0 encodes 4; forced 0 when is_last=0.
- busy  output  1  block held or being emitted; equals out_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, buffer=0, word counter=0.
  - All outputs 0: out_valid, in_ack, is_last, byte_num, out, busy.
- FSM with two states, IDLE and SEND.
- IDLE:
  - in_ack = in_ready, combinational, asserted only in IDLE.
  - On a clock edge with in_ack=1: buffer <= in, counter <= 0, state <= SEND.
- SEND:
  - out_valid=1; out = buffer[IN_WIDTH-1 -: 32].
  - in_ack=0; in_ready is ignored.
- Transfer occurs when out_valid & out_accept.
  - Not the last word: buffer shifts left 32 with zero fill; counter increments.
  - Last word (counter == WORDS-1): state <= IDLE; buffer cleared.
- is_last = SEND & (counter == WORDS-1).
- byte_num = DIGEST_BYTES mod 4 when is_last=1, else 0.
- When DIGEST_BYTES mod 4 != 0, the unused low-order bytes of the last word are driven as 0. Valid bytes occupy out[31:24] downward.
- Stall: while out_accept=0 in SEND, out, is_last, byte_num and counter hold stable. No timeout.
- Latency:
  - In-handshake edge to first out_valid: 1 cycle.
  - Minimum cycles per block: WORDS + 1 (one mandatory IDLE cycle between blocks, even with in_ready held high).
- Simultaneous events:
  - Last-word transfer with in_ready=1 in the same cycle: the new block is not acked that cycle; it is acked in the following IDLE cycle.
- out_accept while out_valid=0 is ignored.
- Reset asserted mid-block aborts the block. No partial words are emitted after reset is released; the first activity after release is a fresh in_ack.
- Counter width: clog2(WORDS) bits, minimum 1. No wrap-around is reachable because the counter is cleared on capture.

Test Plan:
- Reset: hold reset=0 with in_ready=1 and out_accept=1 -> out_valid=0, in_ack=0, out=0 throughout; first in_ack on the first edge after release.
- Default params, in = 576-bit ramp with word k = 32'h0000_0000+k counted from the MSB, out_accept=1 -> in_ack 1 cycle; words 0..15 on 16 consecutive cycles; is_last only with word 15; byte_num=0; words 16-17 never appear.
- Backpressure: toggle out_accept 1,0,0,1,... -> each word is held stable while out_accept=0; sequence and count unchanged; total cycles = 16 + number of stall cycles.
- DIGEST_BYTES=28, IN_WIDTH=576 -> 7 words; word 6 has is_last=1, byte_num=0. DIGEST_BYTES=30 -> 8 words; last word = top 16 bits of source word 7 in out[31:16], out[15:0]=0, byte_num=2.
- in_ready held high with two blocks A and B, out_accept=1 -> A's 16 words, one idle cycle with in_ack=1, then B's 16 words; in_ack pulses only in IDLE cycles.
- reset pulsed low after word 5 of a block -> out_valid drops immediately (asynchronous); after release, next in_ready yields a fresh block starting at word 0.
